// File: rtl/spi_register_bank.sv
// spi_register_bank: SPI mode-0 write-only bank of five 8-bit config registers.
// Pins are synchronized into clk; 16-bit frames commit on nCS rise if valid.
module spi_register_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic sclk_hist, ncs_hist;
    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise, frame_valid;
    logic [15:0] shift_reg;
    logic [4:0] count;
    logic [7:0] regs [5];

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    // ncs chain resets low so a frame already in progress at reset release never looks like a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_hist <= sclk_s;
            ncs_hist  <= ncs_s;
        end
    end

    always_comb begin
        sclk_rise   = sclk_s & ~sclk_hist;
        ncs_fall    = ~ncs_s & ncs_hist;
        ncs_rise    = ncs_s & ~ncs_hist;
        frame_valid = (count == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= 7'(MAX_ADDR));
        state_next  = (state == IDLE)  ? (ncs_fall ? SHIFT : IDLE) :
                      (state == SHIFT) ? (ncs_rise ? COMMIT : SHIFT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            count     <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (state == IDLE && ncs_fall) begin
                count     <= '0;
                frame_err <= 1'b0;
            end
            // a coincident nCS rise ends the frame, so that sclk edge is not shifted
            if (state == SHIFT && sclk_rise && !ncs_rise) begin
                shift_reg <= {shift_reg[14:0], copi_s};
                count     <= (count == 5'd17) ? count : count + 5'd1;
            end
            if (state == COMMIT) begin
                if (frame_valid) begin
                    regs[shift_reg[10:8]] <= shift_reg[7:0];
                    wr_strobe <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];
endmodule
